// File: rtl/apb_rr_scheduler.sv
// ---------------------------------------------------------------------------
// apb_rr_scheduler
//   Round-robin arbiter in front of a single APB master port. Each requester
//   holds arb_req with its direction/address/write data until it receives a
//   one-cycle arb_ack carrying the read data and error status. The winner is
//   the lowest requesting index at or after rr_ptr (wrapping); rr_ptr moves
//   past the served requester on completion.
//
//   Optional feature (macro APB_RR_TIMEOUT_EN): an ACCESS-phase watchdog ends
//   a transfer with arb_err=1 after TIMEOUT_CYCLES cycles without PREADY.
//   Without the macro, ACCESS waits for PREADY indefinitely.
//
// Ports
//   PCLK, PRESET        clock, asynchronous active-low reset
//   arb_req   [NREQ]    per-requester request, held until arb_ack
//   arb_write [NREQ]    per-requester direction (1 = write)
//   arb_addr  [32*NREQ] per-requester address, requester i at [32i+31:32i]
//   arb_wdata [32*NREQ] per-requester write data, packed as arb_addr
//   arb_ack   [NREQ]    one-hot completion pulse
//   arb_rdata [32]      read data (0 for writes), valid with arb_ack
//   arb_err             PSLVERR or timeout, valid with arb_ack
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB master outputs (registered)
//   PRDATA, PREADY, PSLVERR                APB completer response
// ---------------------------------------------------------------------------
module apb_rr_scheduler #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NREQ-1:0]    arb_req,
  input  logic [NREQ-1:0]    arb_write,
  input  logic [32*NREQ-1:0] arb_addr,
  input  logic [32*NREQ-1:0] arb_wdata,
  output logic [NREQ-1:0]    arb_ack,
  output logic [31:0]        arb_rdata,
  output logic               arb_err,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PADDR,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  if (NREQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_rr_scheduler: NREQ and TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cur_idx;

  // Unpacked views of the packed per-requester payload buses.
  logic [31:0] addr_arr  [NREQ];
  logic [31:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = arb_addr[32*g +: 32];
    assign wdata_arr[g] = arb_wdata[32*g +: 32];
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    wrap_idx = IDX_W'(v % NREQ);
  endfunction

  // The requester being acked this cycle is excluded so a still-high request
  // cannot win a second transfer from its own completion cycle.
  logic [NREQ-1:0]  eligible;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [NREQ-1:0]  ack_onehot;

  assign eligible = arb_req & ~arb_ack;

  // NOTE: every variable written in an always_comb block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Scan from the farthest offset down so the nearest one at or after
    // rr_ptr is the last (winning) assignment.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[wrap_idx(int'(rr_ptr) + k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  always_comb begin
    ack_onehot          = '0;
    ack_onehot[cur_idx] = 1'b1;
  end

  logic timeout_hit;

`ifdef APB_RR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires in the TIMEOUT_CYCLES-th consecutive ACCESS cycle without PREADY.
  assign timeout_hit = (state == ST_ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE && grant_valid) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESET) begin
    // NOTE: only control and output registers are reset; the payload is fully
    // reloaded on every grant, so there is no storage left holding stale data.
    if (!PRESET) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      arb_ack   <= '0;
      arb_rdata <= '0;
      arb_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      // Completion outputs are single-cycle pulses.
      arb_ack   <= '0;
      arb_rdata <= '0;
      arb_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state   <= ST_SETUP;
            cur_idx <= grant_idx;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= arb_write[grant_idx];
            PADDR   <= addr_arr[grant_idx];
            PWDATA  <= arb_write[grant_idx] ? wdata_arr[grant_idx] : 32'd0;
          end
        end

        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end

        ST_ACCESS: begin
          if (PREADY || timeout_hit) begin
            state     <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            arb_ack   <= ack_onehot;
            // A timeout never samples PRDATA: the bus may hold anything.
            arb_rdata <= (PREADY && !PWRITE) ? PRDATA : 32'd0;
            arb_err   <= PREADY ? PSLVERR : 1'b1;
            rr_ptr    <= wrap_idx(int'(cur_idx) + 1);
          end
        end

        default: begin
          state   <= ST_IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_rr_scheduler.md
APB_RR_SCHEDULER -- requirements
Module: apb_rr_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the APB master port.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: ACCESS-phase wait limit, used only under APB_RR_TIMEOUT_EN.
REQ-003 PCLK  input  1  single clock; all state updates on rising edge.
REQ-004 PRESET  input  1  reset, asynchronous, active-low.
REQ-005 arb_req  input  NREQ  per-requester transfer request, held until the matching arb_ack.
REQ-006 arb_write  input  NREQ  per-requester direction; 1 = write.
REQ-007 arb_addr  input  32*NREQ  per-requester address; requester i occupies bits [32i+31:32i].
REQ-008 arb_wdata  input  32*NREQ  per-requester write data, packed as arb_addr.
REQ-009 arb_ack  output  NREQ  one-hot, single-cycle completion pulse to the served requester.
REQ-010 arb_rdata  output  32  read data, valid only in the arb_ack cycle.
REQ-011 arb_err  output  1  error flag, valid only in the arb_ack cycle.
REQ-012 PSEL, PENABLE, PWRITE  output  1 each  APB master control.
REQ-013 PADDR, PWDATA  output  32 each  APB master address and write data.
REQ-014 PRDATA  input  32; PREADY, PSLVERR  input  1 each  APB completer response.

Function
REQ-015 The FSM SHALL have three states, IDLE, SETUP and ACCESS, all outputs registered.
REQ-016 IDLE: if any eligible arb_req bit is set, the block SHALL grant the lowest index at or after rr_ptr (wrapping modulo NREQ), latch that requester's write, addr and wdata, and go to SETUP.
REQ-017 SETUP: PSEL=1, PENABLE=0, with PADDR, PWRITE and PWDATA from the latched values; the FSM SHALL go to ACCESS unconditionally on the next cycle.
REQ-018 ACCESS: PSEL=1, PENABLE=1, with all APB outputs held stable until PREADY=1 is sampled.
REQ-019 On PREADY=1 in ACCESS, the next cycle SHALL have:
- arb_ack[idx]=1;
- arb_rdata=PRDATA for a read, 0 for a write;
- arb_err=PSLVERR;
- PSEL=PENABLE=0;
- rr_ptr=(idx+1) mod NREQ;
- state IDLE.
REQ-020 In the IDLE cycle coinciding with arb_ack, the acked requester SHALL be masked from arbitration; requesters SHALL drop arb_req in that cycle.
REQ-021 Minimum latency: arb_req sampled at edge 0 -> PSEL at cycle 1 -> PENABLE at cycle 2 -> arb_ack at cycle 3 (zero-wait slave); a back-to-back grant is possible in the ack cycle.
REQ-022 Payload changes or arb_req deassertion after the grant SHALL be ignored; the latched transfer completes.
REQ-023 With a single requester active, it SHALL be granted every arbitration regardless of rr_ptr.
REQ-024 PWDATA SHALL be 0 for read transfers; PADDR SHALL be held at its last value in IDLE.

Reset
REQ-025 PRESET=0 SHALL asynchronously force IDLE, rr_ptr=0, arb_ack=0, arb_rdata=0, arb_err=0, PSEL=PENABLE=PWRITE=0 and PADDR=PWDATA=0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no arb_ack; operation resumes from IDLE on the first edge after deassertion.

Configuration
REQ-027 With APB_RR_TIMEOUT_EN defined:
- a counter SHALL count ACCESS cycles with PREADY=0;
- on reaching TIMEOUT_CYCLES, the transfer SHALL end as in REQ-019 with arb_err=1, arb_rdata=0 and APB deasserted;
- the counter SHALL clear on every entry to SETUP.
REQ-028 Without APB_RR_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY and no counter logic SHALL be present.

Verification
REQ-029 After reset, requester 2 writes addr 0x10, data 0xA5A5A5A5, zero-wait slave -> PSEL cycle 1, PENABLE cycle 2, arb_ack=4'b0100 cycle 3, arb_err=0.
REQ-030 All four requesters assert reads simultaneously, slave returns 0xDEADBEEF -> grant order 0,1,2,3, each ack carrying 0xDEADBEEF.
REQ-031 Read with PREADY delayed 3 cycles and PSLVERR=1 -> PADDR and PWRITE stable throughout, arb_ack 1 cycle after PREADY, arb_err=1.
REQ-032 PRESET pulsed low during ACCESS for requester 1 -> all outputs 0 immediately, no arb_ack, next grant starts from requester 0.
REQ-033 With APB_RR_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0 -> arb_ack with arb_err=1 and arb_rdata=0 after 16 ACCESS cycles; without the macro -> no ack after 100 cycles.
